// File: rtl/jtag_bscan_top.sv
// rtl/jtag_bscan_top.sv - IEEE 1149.1 TAP controller and boundary-scan wrapper
//
// Purpose: 16-state TAP controller, 4-bit instruction register, bypass and
// optional IDCODE data registers, and a boundary-scan register over every
// functional input and output pin.
//
// Optional feature macro: JTAG_IDCODE_EN (IDCODE register present; reset
// selects IDCODE). Without it, code 4'b0010 decodes as BYPASS and reset
// selects BYPASS.
//
// Ports:
//   TCK      in   test clock, the only clock
//   TRST     in   asynchronous active-low reset of all TAP state
//   TMS      in   mode select, sampled on rising TCK
//   TDI      in   serial data in, sampled on rising TCK
//   TDO      out  serial data out, updated on falling TCK
//   TDO_EN   out  high while in Shift-IR or Shift-DR
//   pin_in   in   [N_IN]  functional inputs from pads
//   core_in  out  [N_IN]  functional inputs to core (always pin_in)
//   core_out in   [N_OUT] functional outputs from core
//   pin_out  out  [N_OUT] functional outputs to pads
module jtag_bscan_top #(
    parameter int          N_IN         = 35,
    parameter int          N_OUT        = 49,
    parameter logic [31:0] IDCODE_VALUE = 32'h0000_1001
) (
    input  logic             TCK,
    input  logic             TRST,
    input  logic             TMS,
    input  logic             TDI,
    output logic             TDO,
    output logic             TDO_EN,
    input  logic [N_IN-1:0]  pin_in,
    output logic [N_IN-1:0]  core_in,
    input  logic [N_OUT-1:0] core_out,
    output logic [N_OUT-1:0] pin_out
);

    localparam int N_BSR = N_IN + N_OUT;

    localparam logic [3:0] INSTR_EXTEST = 4'b0000;
    localparam logic [3:0] INSTR_SAMPLE = 4'b0001;
`ifdef JTAG_IDCODE_EN
    localparam logic [3:0] INSTR_IDCODE = 4'b0010;
    localparam logic [3:0] INSTR_RESET  = 4'b0010;
`else
    localparam logic [3:0] INSTR_RESET  = 4'b1111;
`endif

    // IDCODE bit 0 is the marker that distinguishes IDCODE from BYPASS.
    if (IDCODE_VALUE[0] != 1'b1) begin : g_idcode_lsb_check
        $error("IDCODE_VALUE bit 0 must be 1");
    end

    typedef enum logic [3:0] {
        TLR, RTI,
        SEL_DR, CAP_DR, SH_DR, EX1_DR, PAUSE_DR, EX2_DR, UPD_DR,
        SEL_IR, CAP_IR, SH_IR, EX1_IR, PAUSE_IR, EX2_IR, UPD_IR
    } tap_state_e;

    tap_state_e       state_q;
    logic [3:0]       ir_shift_q;
    logic [3:0]       ir_q;
    logic             bypass_q;
    logic [N_BSR-1:0] bsr_shift_q;
    // Only output cells keep an update latch: core_in is always pin_in, so
    // input-cell latches would have no consumer.
    logic [N_OUT-1:0] bsr_upd_q;
    logic             tdo_q;
    logic             sel_bsr;
    logic             dr_lsb;
`ifdef JTAG_IDCODE_EN
    logic [31:0]      idcode_q;
    logic             sel_idcode;

    assign sel_idcode = (ir_q == INSTR_IDCODE);
`endif

    assign sel_bsr = (ir_q == INSTR_EXTEST) || (ir_q == INSTR_SAMPLE);

    always_comb begin
        dr_lsb = bypass_q;
        if (sel_bsr) dr_lsb = bsr_shift_q[0];
`ifdef JTAG_IDCODE_EN
        if (sel_idcode) dr_lsb = idcode_q[0];
`endif
    end

    always_ff @(posedge TCK or negedge TRST) begin
        if (!TRST) begin
            state_q <= TLR;
        end else begin
            case (state_q)
                TLR:      state_q <= TMS ? TLR    : RTI;
                RTI:      state_q <= TMS ? SEL_DR : RTI;
                SEL_DR:   state_q <= TMS ? SEL_IR : CAP_DR;
                CAP_DR:   state_q <= TMS ? EX1_DR : SH_DR;
                SH_DR:    state_q <= TMS ? EX1_DR : SH_DR;
                EX1_DR:   state_q <= TMS ? UPD_DR : PAUSE_DR;
                PAUSE_DR: state_q <= TMS ? EX2_DR : PAUSE_DR;
                EX2_DR:   state_q <= TMS ? UPD_DR : SH_DR;
                UPD_DR:   state_q <= TMS ? SEL_DR : RTI;
                SEL_IR:   state_q <= TMS ? TLR    : CAP_IR;
                CAP_IR:   state_q <= TMS ? EX1_IR : SH_IR;
                SH_IR:    state_q <= TMS ? EX1_IR : SH_IR;
                EX1_IR:   state_q <= TMS ? UPD_IR : PAUSE_IR;
                PAUSE_IR: state_q <= TMS ? EX2_IR : PAUSE_IR;
                EX2_IR:   state_q <= TMS ? UPD_IR : SH_IR;
                UPD_IR:   state_q <= TMS ? SEL_DR : RTI;
                default:  state_q <= TLR;
            endcase
        end
    end

    // Capture and shift stages; only the selected data register moves.
    always_ff @(posedge TCK or negedge TRST) begin
        if (!TRST) begin
            ir_shift_q  <= 4'b0001;
            bypass_q    <= 1'b0;
            bsr_shift_q <= '0;
`ifdef JTAG_IDCODE_EN
            idcode_q    <= '0;
`endif
        end else begin
            case (state_q)
                CAP_IR: ir_shift_q <= 4'b0001;
                SH_IR:  ir_shift_q <= {TDI, ir_shift_q[3:1]};
                CAP_DR: begin
                    if (sel_bsr) bsr_shift_q <= {core_out, pin_in};
`ifdef JTAG_IDCODE_EN
                    else if (sel_idcode) idcode_q <= IDCODE_VALUE;
`endif
                    else bypass_q <= 1'b0;
                end
                SH_DR: begin
                    if (sel_bsr) bsr_shift_q <= {TDI, bsr_shift_q[N_BSR-1:1]};
`ifdef JTAG_IDCODE_EN
                    else if (sel_idcode) idcode_q <= {TDI, idcode_q[31:1]};
`endif
                    else bypass_q <= TDI;
                end
                default: ;
            endcase
        end
    end

    // Falling-edge side: instruction update, boundary update latches, TDO.
    always_ff @(negedge TCK or negedge TRST) begin
        if (!TRST) begin
            ir_q      <= INSTR_RESET;
            bsr_upd_q <= '0;
            tdo_q     <= 1'b0;
        end else begin
            if (state_q == TLR) ir_q <= INSTR_RESET;
            else if (state_q == UPD_IR) ir_q <= ir_shift_q;

            if ((state_q == UPD_DR) && sel_bsr) bsr_upd_q <= bsr_shift_q[N_BSR-1:N_IN];

            case (state_q)
                SH_IR:   tdo_q <= ir_shift_q[0];
                SH_DR:   tdo_q <= dr_lsb;
                default: tdo_q <= 1'b0;
            endcase
        end
    end

    assign TDO     = tdo_q;
    assign TDO_EN  = (state_q == SH_DR) || (state_q == SH_IR);
    assign core_in = pin_in;
    assign pin_out = (ir_q == INSTR_EXTEST) ? bsr_upd_q : core_out;

endmodule

// File: tb/tb_jtag_bscan_top.sv
// tb/tb_jtag_bscan_top.sv - directed self-checking bench for jtag_bscan_top
module tb_jtag_bscan_top;

    logic        TCK = 1'b0;
    logic        TRST;
    logic        TMS;
    logic        TDI;
    logic        TDO;
    logic        TDO_EN;
    logic [34:0] pin_in;
    logic [34:0] core_in;
    logic [48:0] core_out;
    logic [48:0] pin_out;

    int checks = 0;
    int failures = 0;

    logic [127:0] dout;
    logic         en_ok;

    localparam logic [31:0]  IDV     = 32'h0000_1001;
    localparam logic [48:0]  PRELOAD = 49'h1_2345_6789_ABCD;
`ifdef JTAG_IDCODE_EN
    localparam logic [1:0]   RESET_PAT = 2'b01;
`else
    localparam logic [1:0]   RESET_PAT = 2'b10;
`endif

    int path_len [16] = '{3, 0, 1, 2, 3, 3, 4, 5, 4, 2, 3, 4, 4, 5, 6, 5};
    int path_bits[16] = '{7, 0, 1, 1, 1, 5, 5, 21, 13, 3, 3, 3, 11, 11, 43, 27};

    jtag_bscan_top dut (
        .TCK      (TCK),
        .TRST     (TRST),
        .TMS      (TMS),
        .TDI      (TDI),
        .TDO      (TDO),
        .TDO_EN   (TDO_EN),
        .pin_in   (pin_in),
        .core_in  (core_in),
        .core_out (core_out),
        .pin_out  (pin_out)
    );

    always #5 TCK = ~TCK;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic tick(input logic tms, input logic tdi);
        TMS = tms;
        TDI = tdi;
        @(posedge TCK);
        @(negedge TCK);
        #1;
    endtask

    task automatic tick5();
        for (int i = 0; i < 5; i++) tick(1'b1, 1'b0);
    endtask

    // From RTI: load an instruction and return to RTI.
    task automatic shift_ir(input logic [3:0] code);
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) tick(i == 3, code[i]);
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
    endtask

    // From RTI: capture, shift n bits, update, return to RTI.
    task automatic shift_dr(input int n, input logic [127:0] din,
                            output logic [127:0] dq, output logic en);
        dq = '0;
        en = 1'b1;
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        for (int i = 0; i < n; i++) begin
            dq[i] = TDO;
            en    = en & TDO_EN;
            tick(i == n - 1, din[i]);
        end
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        TRST     = 1'b0;
        TMS      = 1'b1;
        TDI      = 1'b0;
        pin_in   = 35'h5_5555_5555;
        core_out = 49'h1_AAAA_AAAA_AAAA;
        #12;
        check("rst_tdo", TDO, 1'b0);
        check("rst_tdo_en", TDO_EN, 1'b0);
        check("rst_pin_out", pin_out, 49'h1_AAAA_AAAA_AAAA);
        check("rst_core_in", core_in, 35'h5_5555_5555);
        TRST = 1'b1;

        // Reset instruction: IDCODE (or BYPASS when compiled out).
        tick(1'b0, 1'b0);
        shift_dr(32, 128'hC3A5_5A3C, dout, en_ok);
`ifdef JTAG_IDCODE_EN
        check("idcode_bits", dout[31:0], IDV);
`else
        check("idcode_bypass_bits", dout[31:0], 32'h874A_B478);
`endif
        check("idcode_tdo_en", en_ok, 1'b1);
        check("rti_tdo_en", TDO_EN, 1'b0);
        check("rti_tdo", TDO, 1'b0);

        // Bypass: capture bit then the pattern one TCK late.
        shift_ir(4'b1111);
        shift_dr(5, 128'b01001, dout, en_ok);
        check("bypass_seq", dout[4:0], 5'b10010);
        shift_ir(4'b0110);
        shift_dr(3, 128'b011, dout, en_ok);
        check("undef_as_bypass", dout[2:0], 3'b110);

        // SAMPLE/PRELOAD: capture pins, preload output cells.
        shift_ir(4'b0001);
        shift_dr(84, {PRELOAD, 35'h0}, dout, en_ok);
        check("sample_capture", dout[83:0], {49'h1_AAAA_AAAA_AAAA, 35'h5_5555_5555});
        check("sample_pin_out", pin_out, 49'h1_AAAA_AAAA_AAAA);
        check("sample_core_in", core_in, 35'h5_5555_5555);

        // EXTEST drives the preloaded values.
        shift_ir(4'b0000);
        check("extest_pin_out", pin_out, PRELOAD);
        core_out = 49'h0_1357_9BDF_0246;
        #1;
        check("extest_core_out_ignored", pin_out, PRELOAD);

        // TRST midway through a 20-bit ShDR under EXTEST.
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        for (int i = 0; i < 10; i++) tick(1'b0, 1'b1);
        check("midshift_tdo_en", TDO_EN, 1'b1);
        #2;
        TRST = 1'b0;
        #1;
        check("trst_tdo", TDO, 1'b0);
        check("trst_tdo_en", TDO_EN, 1'b0);
        check("trst_pin_out", pin_out, 49'h0_1357_9BDF_0246);
        @(negedge TCK);
        #1;
        TRST = 1'b1;
        tick(1'b0, 1'b0);
        shift_ir(4'b0000);
        check("trst_latches_cleared", pin_out, 49'h0);

        // Five TMS=1 edges from every state restore the reset instruction.
        pin_in = '1;
        shift_ir(4'b0001);
        shift_dr(2, 128'b11, dout, en_ok);
        check("sample_ones", dout[1:0], 2'b11);
        for (int s = 0; s < 16; s++) begin
            tick5();
            tick(1'b0, 1'b0);
            shift_ir(4'b0001);
            for (int k = 0; k < path_len[s]; k++) tick(path_bits[s][k], 1'b0);
            tick5();
            tick(1'b0, 1'b0);
            shift_dr(2, 128'b11, dout, en_ok);
            check($sformatf("tlr_from_state_%0d", s), dout[1:0], RESET_PAT);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
